memory_arbiter: RTL and testbench

Two-requester, round-robin arbiter and sequencer for the single-port `Memory` block (WordSize × 2^AddressSize words). It shares the memory between two clients, such as the pointer-chase walker and a preload/debug port. For each access it latches the winning request, drives the memory port for one cycle, captures read data, and returns a one-cycle `Ack`. All outputs are registered, and the block sits directly in front of the `Memory` instance.

---
 rtl/memory_arbiter_pkg.sv | 12 +
 rtl/memory_arbiter_rr_pick.sv | 19 +
 rtl/memory_arbiter.sv | 127 ++++++++++++
 tb/tb_memory_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state encoding and requester ids.
package memory_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, ties go to Prio.
module rr_pick
  import memory_arbiter_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic Prio,
  output logic Grant,
  output logic Any
);

  always_comb begin
    Any = Req0 | Req1;
    if (Req0 && Req1) Grant = Prio;
    else if (Req1)    Grant = REQ1;
    else              Grant = REQ0;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port memory; one access per two cycles.
// Optional grant lock for atomic read-modify-write is enabled with MEM_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | waiting for a request; Ack of the previous access is visible here
// BUSY  | memory port driven with the latched request for exactly one cycle
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WordSize    = 32,
  parameter int AddressSize = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Req0,
  input  logic                   Req1,
  input  logic                   Write0,
  input  logic                   Write1,
  input  logic [AddressSize-1:0] Address0,
  input  logic [AddressSize-1:0] Address1,
  input  logic [WordSize-1:0]    I0,
  input  logic [WordSize-1:0]    I1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                   Lock0,
  input  logic                   Lock1,
`endif
  output logic                   Ack0,
  output logic                   Ack1,
  output logic [WordSize-1:0]    Q,
  output logic                   MemStatus,
  output logic [AddressSize-1:0] MemAddress,
  output logic [WordSize-1:0]    MemI,
  input  logic [WordSize-1:0]    MemQ
);

  arb_state_e             state_q, state_d;
  logic                   prio_q, prio_d;
  logic                   winner_q, winner_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   mem_status_q, mem_status_d;
  logic [WordSize-1:0]    q_q, q_d;
  logic [AddressSize-1:0] mem_addr_q, mem_addr_d;
  logic [WordSize-1:0]    mem_i_q, mem_i_d;

  logic grant;
  logic any_req;
  logic keep_prio;

  rr_pick u_rr_pick (
    .Req0  (Req0),
    .Req1  (Req1),
    .Prio  (prio_q),
    .Grant (grant),
    .Any   (any_req)
  );

`ifdef MEM_ARB_LOCK_EN
  assign keep_prio = (winner_q == REQ1) ? Lock1 : Lock0;
`else
  assign keep_prio = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    winner_d     = winner_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_status_d = 1'b0;
    q_d          = q_q;
    mem_addr_d   = mem_addr_q;
    mem_i_d      = mem_i_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          winner_d     = grant;
          mem_addr_d   = (grant == REQ1) ? Address1 : Address0;
          mem_i_d      = (grant == REQ1) ? I1 : I0;
          mem_status_d = (grant == REQ1) ? Write1 : Write0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // mem_status_q doubles as the latched write flag of the access in flight
        if (!mem_status_q) q_d = MemQ;
        ack0_d  = (winner_q == REQ0);
        ack1_d  = (winner_q == REQ1);
        prio_d  = keep_prio ? winner_q : ~winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      prio_q       <= REQ0;
      winner_q     <= REQ0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_status_q <= 1'b0;
      q_q          <= '0;
      mem_addr_q   <= '0;
      mem_i_q      <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      winner_q     <= winner_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_status_q <= mem_status_d;
      q_q          <= q_d;
      mem_addr_q   <= mem_addr_d;
      mem_i_q      <= mem_i_d;
    end
  end

  assign Ack0       = ack0_q;
  assign Ack1       = ack1_q;
  assign Q          = q_q;
  assign MemStatus  = mem_status_q;
  assign MemAddress = mem_addr_q;
  assign MemI       = mem_i_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural single-port memory attached.
module tb_memory_arbiter;

  logic        Clock;
  logic        Reset;
  logic        Req0, Req1, Write0, Write1;
  logic [7:0]  Address0, Address1;
  logic [31:0] I0, I1;
`ifdef MEM_ARB_LOCK_EN
  logic        Lock0, Lock1;
`endif
  logic        Ack0, Ack1;
  logic [31:0] Q;
  logic        MemStatus;
  logic [7:0]  MemAddress;
  logic [31:0] MemI;
  logic [31:0] MemQ;

  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;
  int n;
  int cnt0;
  logic got;
  logic exp_g [4];
  logic [31:0] preload [8];
  logic [31:0] chase_q [6];

  memory_arbiter #(.WordSize(32), .AddressSize(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req0       (Req0),
    .Req1       (Req1),
    .Write0     (Write0),
    .Write1     (Write1),
    .Address0   (Address0),
    .Address1   (Address1),
    .I0         (I0),
    .I1         (I1),
`ifdef MEM_ARB_LOCK_EN
    .Lock0      (Lock0),
    .Lock1      (Lock1),
`endif
    .Ack0       (Ack0),
    .Ack1       (Ack1),
    .Q          (Q),
    .MemStatus  (MemStatus),
    .MemAddress (MemAddress),
    .MemI       (MemI),
    .MemQ       (MemQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign MemQ = mem[MemAddress];
  always @(posedge Clock) if (MemStatus) mem[MemAddress] <= MemI;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access by requester id; checks 2-edge latency and read data.
  task automatic access(input logic id, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_q, input string tag);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    if (id) begin Req1 = 1'b1; Write1 = wr; Address1 = addr; I1 = data; end
    else    begin Req0 = 1'b1; Write0 = wr; Address0 = addr; I0 = data; end
    while (!seen && k < 6) begin
      step();
      k++;
      seen = id ? Ack1 : Ack0;
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'd2);
    if (!wr && seen) check({tag, "_q"}, 64'(Q), 64'(exp_q));
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    preload = '{32'd4, 32'd1, 32'd3, 32'd4, 32'd2, 32'd5, 32'd6, 32'd0};
    // next address = previous word + 1, starting at address 0
    chase_q = '{32'd4, 32'd5, 32'd6, 32'd0, 32'd1, 32'd3};
`ifdef MEM_ARB_LOCK_EN
    Lock0 = 1'b0; Lock1 = 1'b0;
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    // Reset held with both requests active
    Reset = 1'b1;
    Req0 = 1'b1; Write0 = 1'b1; Address0 = 8'd9; I0 = 32'hAA;
    Req1 = 1'b1; Write1 = 1'b0; Address1 = 8'd7; I1 = 32'hBB;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ack0", 64'(Ack0), 64'd0);
      check("rst_ack1", 64'(Ack1), 64'd0);
      check("rst_q", 64'(Q), 64'd0);
      check("rst_memstatus", 64'(MemStatus), 64'd0);
      check("rst_memaddr", 64'(MemAddress), 64'd0);
    end
    Req0 = 1'b0; Req1 = 1'b0; Reset = 1'b0;
    step();

    // Write then read, step by step
    Req0 = 1'b1; Write0 = 1'b1; Address0 = 8'd5; I0 = 32'd5;
    step();
    check("wr_memstatus_busy", 64'(MemStatus), 64'd1);
    check("wr_memaddr", 64'(MemAddress), 64'd5);
    check("wr_memi", 64'(MemI), 64'd5);
    check("wr_ack0_early", 64'(Ack0), 64'd0);
    step();
    check("wr_ack0", 64'(Ack0), 64'd1);
    check("wr_memstatus_done", 64'(MemStatus), 64'd0);
    Req0 = 1'b0;
    step();
    check("wr_ack0_cleared", 64'(Ack0), 64'd0);
    check("wr_memstatus_idle", 64'(MemStatus), 64'd0);
    check("wr_memaddr_hold", 64'(MemAddress), 64'd5);
    access(1'b1, 1'b0, 8'd5, 32'd0, 32'd5, "rd5");

    // Preload and pointer chase
    for (int i = 0; i < 8; i++) access(1'b0, 1'b1, 8'(i), preload[i], 32'd0, "preload");
    for (int i = 0; i < 6; i++)
      access(1'b1, 1'b0, (i == 0) ? 8'd0 : 8'(chase_q[i-1] + 32'd1), 32'd0, chase_q[i], "chase");

    // Contention: both reads held, grants must alternate starting at 0
    Reset = 1'b1; step(); Reset = 1'b0;
    Req0 = 1'b1; Write0 = 1'b0; Address0 = 8'd1;
    Req1 = 1'b1; Write1 = 1'b0; Address1 = 8'd2;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("cont_ack0", 64'(Ack0), 64'((k == 2) || (k == 6)));
      check("cont_ack1", 64'(Ack1), 64'((k == 4) || (k == 8)));
      if (k == 2 || k == 6) check("cont_q0", 64'(Q), 64'd1);
      if (k == 4 || k == 8) check("cont_q1", 64'(Q), 64'd3);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    step(); step();

    // Lock: requester 0 keeps the grant while locked (alternation when not built in)
    Reset = 1'b1; step(); Reset = 1'b0;
    Req0 = 1'b1; Write0 = 1'b0; Address0 = 8'd1;
    Req1 = 1'b1; Write1 = 1'b0; Address1 = 8'd2;
`ifdef MEM_ARB_LOCK_EN
    Lock0 = 1'b1;
`endif
    cnt0 = 0;
    for (int a = 0; a < 4; a++) begin
      n = 0; got = 1'b0;
      while (!got && n < 6) begin
        step();
        n++;
        got = Ack0 | Ack1;
      end
      check("lock_wait", 64'(got), 64'd1);
      check("lock_ack1", 64'(Ack1), 64'(exp_g[a]));
      check("lock_ack0", 64'(Ack0), 64'(!exp_g[a]));
      if (Ack0) cnt0++;
      if (cnt0 == 3) begin
        Req0 = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        Lock0 = 1'b0;
`endif
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    step(); step();

    // Reset during the BUSY cycle of a read
    access(1'b1, 1'b0, 8'd2, 32'd0, 32'd3, "pre_midrst");
    Req0 = 1'b1; Write0 = 1'b0; Address0 = 8'd0;
    step();
    check("midrst_busy_addr", 64'(MemAddress), 64'd0);
    Reset = 1'b1; Req0 = 1'b0;
    step();
    check("midrst_ack0", 64'(Ack0), 64'd0);
    check("midrst_ack1", 64'(Ack1), 64'd0);
    check("midrst_q", 64'(Q), 64'd0);
    check("midrst_memstatus", 64'(MemStatus), 64'd0);
    Reset = 1'b0;
    step();
    check("midrst_no_late_ack", 64'(Ack0), 64'd0);
    access(1'b1, 1'b0, 8'd6, 32'd0, 32'd6, "post_midrst");
    check("mem_intact_5", 64'(mem[5]), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
